// File: rtl/mult_pkg.sv
// Shared constants and state type for the 16x16 shift-add multiplier.
// Imported by shift_add_mult16 and its adder.
package mult_pkg;

  localparam int N  = 16;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mult_state_t;

endpackage

// File: rtl/cla16bit.sv
// 16-bit two-level carry-lookahead adder.
// Four 4-bit groups with group generate/propagate feeding a lookahead unit.
module cla16bit
  import mult_pkg::*;
(
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N-1:0] c;
  logic [3:0]   gg;
  logic [3:0]   pg;
  logic [4:0]   cg;

  assign g = a & b;
  assign p = a ^ b;

  for (genvar k = 0; k < 4; k++) begin : g_grp
    localparam int B = 4 * k;

    assign gg[k] = g[B+3]
                 | (p[B+3] & g[B+2])
                 | (p[B+3] & p[B+2] & g[B+1])
                 | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign pg[k] = &p[B+3:B];

    assign c[B]   = cg[k];
    assign c[B+1] = g[B]
                  | (p[B] & cg[k]);
    assign c[B+2] = g[B+1]
                  | (p[B+1] & g[B])
                  | (p[B+1] & p[B] & cg[k]);
    assign c[B+3] = g[B+2]
                  | (p[B+2] & g[B+1])
                  | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & cg[k]);
  end

  assign cg[0] = cin;
  assign cg[1] = gg[0]
               | (pg[0] & cin);
  assign cg[2] = gg[1]
               | (pg[1] & gg[0])
               | (pg[1] & pg[0] & cin);
  assign cg[3] = gg[2]
               | (pg[2] & gg[1])
               | (pg[2] & pg[1] & gg[0])
               | (pg[2] & pg[1] & pg[0] & cin);
  assign cg[4] = gg[3]
               | (pg[3] & gg[2])
               | (pg[3] & pg[2] & gg[1])
               | (pg[3] & pg[2] & pg[1] & gg[0])
               | (pg[3] & pg[2] & pg[1] & pg[0] & cin);

  assign sum  = p ^ c;
  assign cout = cg[4];

endmodule

// File: rtl/shift_add_mult16.sv
// Sequential 16x16 unsigned shift-and-add multiplier over cla16bit.
// Optional ZERO_SKIP_EN: zero operands finish after a single cycle.
module shift_add_mult16
  import mult_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2*N-1:0] product
);

  mult_state_t   state;
  logic [N-1:0]  mcand;
  logic [N-1:0]  hi;
  logic [N-1:0]  lo;
  logic [CW-1:0] count;

  logic [N-1:0]  addend;
  logic [N-1:0]  sum;
  logic          c;
  logic [N-1:0]  hi_nxt;
  logic [N-1:0]  lo_nxt;

  assign in_ready = (state == IDLE) && !rst;

  assign addend = lo[0] ? mcand : '0;
  assign hi_nxt = {c, sum[N-1:1]};
  assign lo_nxt = {sum[0], lo[N-1:1]};

  cla16bit u_add (
    .a    (hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (c)
  );

  // Control FSM plus operand/accumulator and registered product.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mcand     <= '0;
      hi        <= '0;
      lo        <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      product   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mcand <= a;
            hi    <= '0;
            lo    <= b;
            count <= '0;
            state <= RUN;
`ifdef ZERO_SKIP_EN
            // A zero operand runs one all-zero final iteration.
            if (a == '0 || b == '0) begin
              lo    <= '0;
              count <= CW'(N - 1);
            end
`endif
          end
        end
        RUN: begin
          hi    <= hi_nxt;
          lo    <= lo_nxt;
          count <= count + CW'(1);
          if (count == CW'(N - 1)) begin
            product   <= {hi_nxt, lo_nxt};
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult16.sv
// Directed self-checking bench for shift_add_mult16.
// Expected products are hand-computed constants.
module tb_shift_add_mult16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;

  int total = 0;
  int bad   = 0;

  shift_add_mult16 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag,
                     input logic [15:0] ia,
                     input logic [15:0] ib,
                     input logic [31:0] exp,
                     input int lat,
                     input int hold,
                     input bit keep_valid);
    int n;
    bit stable;
    check({tag, "_rdy0"}, 32'(in_ready), 32'd1);
    a         = ia;
    b         = ib;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    step();
    if (!keep_valid)
      in_valid = 1'b0;
    check({tag, "_busy"}, 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 40) begin
      if (keep_valid) begin
        a = 16'($urandom);
        b = 16'($urandom);
      end
      step();
      n++;
    end
    in_valid = 1'b0;
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_prod"}, product, exp);
    if (hold > 0) begin
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        step();
        if (!out_valid || product !== exp)
          stable = 1'b0;
      end
      check({tag, "_hold"}, 32'(stable), 32'd1);
      out_ready = 1'b1;
    end
    step();
    out_ready = 1'b0;
    check({tag, "_ov0"}, 32'(out_valid), 32'd0);
    check({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int zlat;
`ifdef ZERO_SKIP_EN
    zlat = 1;
`else
    zlat = 16;
`endif
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) step();
    check("rst_rdy", 32'(in_ready), 32'd0);
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_prod", product, 32'd0);
    in_valid = 1'b1;
    a        = 16'd9;
    b        = 16'd9;
    step();
    check("rst_noacc", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    check("post_rst_rdy", 32'(in_ready), 32'd1);

    run("m3x5", 16'd3, 16'd5, 32'h0000_000F, 16, 0, 1'b0);
    run("mffff", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 16, 0, 1'b0);
    run("bp", 16'h1234, 16'h00FF, 32'h0012_21CC, 16, 10, 1'b0);

    a        = 16'hABCD;
    b        = 16'h1357;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (8) step();
    check("mid_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("mid_ov", 32'(out_valid), 32'd0);
    check("mid_prod", product, 32'd0);
    check("mid_rdy", 32'(in_ready), 32'd1);
    run("m2x7", 16'd2, 16'd7, 32'h0000_000E, 16, 0, 1'b0);

    run("hold_iv", 16'h00FF, 16'h0101, 32'h0000_FFFF, 16, 0, 1'b1);
    run("zero", 16'h0000, 16'h1234, 32'h0000_0000, zlat, 0, 1'b0);
    run("odd", 16'h8001, 16'h0003, 32'h0001_8003, 16, 2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
